// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg : fetch-stage state encoding, NOP word, instruction field positions
//             and base opcodes shared with the control unit.
// Revision  : 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB       = 0;
  localparam int OP_MSB       = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit_if : instruction-memory req/ack bus between fetch and imem.
// Revision            : 1.0
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ----------------------------------------------------------------------------
// next_pc_logic : selects pc+4 or the taken target and flags unaligned targets.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module next_pc_logic
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_target,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic w_pc_src;

  assign w_pc_src = jump | (branch & zero);

  // Alignment only matters when the target is actually taken.
  assign misaligned = w_pc_src & ~is_word_aligned(pc_target[1:0]);
  assign next_pc    = w_pc_src ? pc_target : (pc + XLEN'(4));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit : PC register, req/ack instruction fetch, decode field split
//                    and next-PC update for the single-cycle core.
// Revision         : 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        imem,
  input  logic                      branch,
  input  logic                      jump,
  input  logic                      zero,
  input  logic [XLEN-1:0]           pc_target,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           pc_plus4,
  output logic [6:0]                op,
  output logic [2:0]                funct3,
  output logic                      funct7_5,
  output logic                      misaligned_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  next_pc_logic #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc         (pc_q),
    .pc_target  (pc_target),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .next_pc    (w_next_pc),
    .misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // An unaligned taken target is fatal: freeze everything until reset.
        if (w_misaligned) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          pc_d    = w_next_pc;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Gated by reset so no request or commit is seen while reset is held.
  assign imem.imem_req  = (state_q == FETCH) && !reset;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == EXEC) && !reset;

  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + XLEN'(4);
  assign op             = instr_q[OP_MSB:OP_LSB];
  assign funct3         = instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7_5       = instr_q[FUNCT7_5_BIT];
  assign misaligned_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : randomized self-checking bench for instr_fetch_unit.
// Revision            : 1.0
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch, jump, zero;
  logic [31:0] pc_target;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, funct7_5, misaligned_err;
  logic [6:0]  op;
  logic [2:0]  funct3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  bit          m_halt;

  instr_fetch_unit_if #(.XLEN(32)) imem_if ();

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_if),
    .branch         (branch),
    .jump           (jump),
    .zero           (zero),
    .pc_target      (pc_target),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .op             (op),
    .funct3         (funct3),
    .funct7_5       (funct7_5),
    .misaligned_err (misaligned_err)
  );

  always #5 clk = ~clk;

  // Reference: taken = jump or (branch and zero); unaligned taken target halts.
  function automatic void model_exec(input logic br, input logic jmp, input logic z,
                                     input logic [31:0] tgt);
    bit taken;
    taken = jmp || (br && z);
    if (taken && (tgt % 4) != 0) m_halt = 1'b1;
    else if (taken)              m_pc   = tgt;
    else                         m_pc   = m_pc + 32'd4;
  endfunction

  task automatic fetch_step(input int waits, input logic [31:0] word,
                            output logic [31:0] first_addr, output int addr_moves,
                            output int req_lows, output int valid_hits);
    first_addr = imem_if.imem_addr;
    addr_moves = 0;
    req_lows   = 0;
    valid_hits = 0;
    for (int i = 0; i <= waits; i++) begin
      if (imem_if.imem_addr !== first_addr) addr_moves++;
      if (imem_if.imem_req !== 1'b1) req_lows++;
      if (instr_valid !== 1'b0) valid_hits++;
      imem_if.imem_ack   = (i == waits);
      imem_if.imem_rdata = (i == waits) ? word : $urandom;
      @(negedge clk);
    end
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = $urandom;
  endtask

  task automatic exec_step(input logic br, input logic jmp, input logic z,
                           input logic [31:0] tgt);
    branch    = br;
    jump      = jmp;
    zero      = z;
    pc_target = tgt;
    @(negedge clk);
    branch    = 1'b0;
    jump      = 1'b0;
    zero      = 1'($urandom_range(0, 1));
    pc_target = $urandom;
    model_exec(br, jmp, z, tgt);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = $urandom;
    repeat (3) @(negedge clk);
    n_checks++; if (pc !== C_RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, C_RESET_PC); end
    n_checks++; if (instr !== C_NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, C_NOP); end
    n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", misaligned_err); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    n_checks++; if (op !== 7'h13) begin n_fail++; $display("FAIL reset_op: got %h expected 13", op); end
    reset = 1'b0;
    imem_if.imem_ack = 1'b0;
    #1;
    n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_if.imem_req); end
    n_checks++; if (imem_if.imem_addr !== C_RESET_PC) begin n_fail++; $display("FAIL first_addr: got %h expected %h", imem_if.imem_addr, C_RESET_PC); end
    m_pc   = C_RESET_PC;
    m_halt = 1'b0;
  endtask

  task automatic test_first_instr;
    logic [31:0] a;
    int mv, rl, vh;
    fetch_step(0, 32'h0050_0093, a, mv, rl, vh);
    n_checks++; if (a !== m_pc) begin n_fail++; $display("FAIL fi_addr: got %h expected %h", a, m_pc); end
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL fi_valid: got %b expected 1", instr_valid); end
    n_checks++; if (op !== 7'h13) begin n_fail++; $display("FAIL fi_op: got %h expected 13", op); end
    n_checks++; if (funct3 !== 3'd0) begin n_fail++; $display("FAIL fi_funct3: got %h expected 0", funct3); end
    n_checks++; if (funct7_5 !== 1'b0) begin n_fail++; $display("FAIL fi_f7: got %b expected 0", funct7_5); end
    n_checks++; if (pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL fi_pc4: got %h expected 4", pc_plus4); end
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL fi_instr: got %h expected 00500093", instr); end
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_if.imem_addr !== 32'd4) begin n_fail++; $display("FAIL fi_next_addr: got %h expected 4", imem_if.imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL fi_one_pulse: got %b expected 0", instr_valid); end
  endtask

  task automatic test_wait_states;
    int waits_tab [4] = '{3, 1, 2, 0};
    logic [31:0] a, word;
    int mv, rl, vh;
    foreach (waits_tab[k]) begin
      word = $urandom;
      fetch_step(waits_tab[k], word, a, mv, rl, vh);
      n_checks++; if (a !== m_pc) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h expected %h", k, a, m_pc); end
      n_checks++; if (mv !== 0) begin n_fail++; $display("FAIL ws_addr_stable[%0d]: got %0d moves expected 0", k, mv); end
      n_checks++; if (rl !== 0) begin n_fail++; $display("FAIL ws_req[%0d]: got %0d low cycles expected 0", k, rl); end
      n_checks++; if (vh !== 0) begin n_fail++; $display("FAIL ws_early_valid[%0d]: got %0d expected 0", k, vh); end
      n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid[%0d]: got %b expected 1", k, instr_valid); end
      n_checks++; if (instr !== word) begin n_fail++; $display("FAIL ws_instr[%0d]: got %h expected %h", k, instr, word); end
      n_checks++; if ({funct7_5, funct3, op} !== {word[30], word[14:12], word[6:0]}) begin
        n_fail++; $display("FAIL ws_fields[%0d]: got %h expected %h", k, {funct7_5, funct3, op}, {word[30], word[14:12], word[6:0]});
      end
      exec_step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ws_one_pulse[%0d]: got %b expected 0", k, instr_valid); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev_word, word;
    int pulses = 0;
    imem_if.imem_ack = 1'b1;
    prev_word = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid === 1'b1) pulses++;
      n_checks++; if (instr_valid !== ((k % 2) == 1)) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, instr_valid, (k % 2) == 1); end
      if ((k % 2) == 1) begin
        n_checks++; if (instr !== prev_word) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h expected %h", k, instr, prev_word); end
        n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h expected %h", k, pc, m_pc); end
      end else begin
        n_checks++; if (imem_if.imem_addr !== m_pc) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, imem_if.imem_addr, m_pc); end
      end
      word = $urandom;
      imem_if.imem_rdata = word;
      @(negedge clk);
      if ((k % 2) == 1) m_pc = m_pc + 32'd4;
      else              prev_word = word;
    end
    imem_if.imem_ack = 1'b0;
    n_checks++; if (pulses !== 6) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 6", pulses); end
  endtask

  task automatic test_branch;
    logic [31:0] a, base;
    int mv, rl, vh;
    fetch_step(0, $urandom, a, mv, rl, vh);
    exec_step(1'b1, 1'b0, 1'b1, 32'h40);
    n_checks++; if (imem_if.imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_taken: got %h expected 40", imem_if.imem_addr); end
    fetch_step(1, $urandom, a, mv, rl, vh);
    exec_step(1'b1, 1'b0, 1'b0, 32'h80);
    n_checks++; if (imem_if.imem_addr !== 32'h44) begin n_fail++; $display("FAIL br_not_taken: got %h expected 44", imem_if.imem_addr); end
    fetch_step(0, $urandom, a, mv, rl, vh);
    exec_step(1'b1, 1'b0, 1'b0, 32'h123);
    n_checks++; if (imem_if.imem_addr !== 32'h48) begin n_fail++; $display("FAIL br_nt_unaligned: got %h expected 48", imem_if.imem_addr); end
    n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL br_nt_err: got %b expected 0", misaligned_err); end
    // Random control flow, taken targets kept aligned so the core keeps running.
    for (int n = 0; n < 24; n++) begin
      logic br, jmp, z;
      logic [31:0] tgt, word;
      br   = 1'($urandom_range(0, 1));
      jmp  = ($urandom_range(0, 3) == 0);
      z    = 1'($urandom_range(0, 1));
      tgt  = $urandom;
      if (jmp || (br && z)) tgt = tgt & 32'hFFFF_FFFC;
      word = $urandom;
      base = m_pc;
      fetch_step($urandom_range(0, 2), word, a, mv, rl, vh);
      n_checks++; if (a !== base) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, a, base); end
      n_checks++; if ({instr_valid, instr} !== {1'b1, word}) begin n_fail++; $display("FAIL rnd_exec[%0d]: got %b/%h expected 1/%h", n, instr_valid, instr, word); end
      n_checks++; if (pc_plus4 !== base + 32'd4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %h expected %h", n, pc_plus4, base + 32'd4); end
      exec_step(br, jmp, z, tgt);
    end
    n_checks++; if (imem_if.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_final_addr: got %h expected %h", imem_if.imem_addr, m_pc); end
    n_checks++; if (misaligned_err !== m_halt) begin n_fail++; $display("FAIL rnd_err: got %b expected %b", misaligned_err, m_halt); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    int mv, rl, vh;
    fetch_step(0, $urandom, a, mv, rl, vh);
    exec_step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    n_checks++; if (imem_if.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump: got %h expected fffffffc", imem_if.imem_addr); end
    fetch_step(2, $urandom, a, mv, rl, vh);
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", pc_plus4); end
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_if.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", imem_if.imem_addr); end
    n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b expected 0", misaligned_err); end
  endtask

  task automatic test_misaligned;
    logic [31:0] a, word, pc_before;
    int mv, rl, vh, req_hi, val_hi, pc_mv, ins_mv;
    word = $urandom;
    fetch_step(0, word, a, mv, rl, vh);
    pc_before = m_pc;
    exec_step(1'b0, 1'b1, 1'b0, 32'h42);
    n_checks++; if (misaligned_err !== m_halt) begin n_fail++; $display("FAIL mis_err: got %b expected %b", misaligned_err, m_halt); end
    n_checks++; if (pc !== pc_before) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc, pc_before); end
    req_hi = 0; val_hi = 0; pc_mv = 0; ins_mv = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_if.imem_req !== 1'b0) req_hi++;
      if (instr_valid !== 1'b0) val_hi++;
      if (pc !== pc_before) pc_mv++;
      if (instr !== word) ins_mv++;
      imem_if.imem_ack   = 1'($urandom_range(0, 1));
      imem_if.imem_rdata = $urandom;
      branch = 1'b1; jump = 1'b1; zero = 1'b1;
      @(negedge clk);
    end
    branch = 1'b0; jump = 1'b0; imem_if.imem_ack = 1'b0;
    n_checks++; if (req_hi !== 0) begin n_fail++; $display("FAIL halt_req: got %0d high cycles expected 0", req_hi); end
    n_checks++; if (val_hi !== 0) begin n_fail++; $display("FAIL halt_valid: got %0d high cycles expected 0", val_hi); end
    n_checks++; if ({pc_mv, ins_mv} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL halt_frozen: got pc %0d / instr %0d changes expected 0/0", pc_mv, ins_mv); end
    n_checks++; if (misaligned_err !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b expected 1", misaligned_err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_pc = C_RESET_PC; m_halt = 1'b0;
    n_checks++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b expected 0", misaligned_err); end
    n_checks++; if (imem_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_restart: got %b expected 1", imem_if.imem_req); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a;
    int mv, rl, vh;
    @(negedge clk);                    // first FETCH cycle, no ack
    reset = 1'b1;                      // second cycle: reset with ack
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    imem_if.imem_ack = 1'b0;
    #1;
    n_checks++; if (instr !== C_NOP) begin n_fail++; $display("FAIL rm_instr: got %h expected %h", instr, C_NOP); end
    n_checks++; if (pc !== C_RESET_PC) begin n_fail++; $display("FAIL rm_pc: got %h expected %h", pc, C_RESET_PC); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b expected 0", instr_valid); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_pulse: got %b expected 0", instr_valid); end
    // Reset during EXEC abandons the instruction and does not advance pc.
    fetch_step(0, $urandom, a, mv, rl, vh);
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    fetch_step(1, $urandom, a, mv, rl, vh);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_pc = C_RESET_PC;
    n_checks++; if ({pc, instr} !== {C_RESET_PC, C_NOP}) begin n_fail++; $display("FAIL rm_exec: got %h/%h expected %h/%h", pc, instr, C_RESET_PC, C_NOP); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_exec_valid: got %b expected 0", instr_valid); end
  endtask

  initial begin
    reset              = 1'b1;
    branch             = 1'b0;
    jump               = 1'b0;
    zero               = 1'b0;
    pc_target          = 32'h0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    m_pc               = C_RESET_PC;
    m_halt             = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_instr();
    test_wait_states();
    test_back_to_back();
    test_branch();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit in the single-cycle RISC-V core.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake.
- Splits the fetched word into the op, funct3 and funct7_5 fields the control unit decodes.
- Computes the next PC from the branch/jump/zero results of the executed instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width (only 32 supported).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, high throughout FETCH.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- branch  input  1  from control: current instruction is a branch.
- jump  input  1  from control: current instruction is a jump.
- zero  input  1  ALU zero flag from datapath.
- pc_target  input  XLEN  branch/jump target from datapath.
- instr  output  32  held instruction word.
- instr_valid  output  1  high for exactly one cycle per instruction (EXEC); datapath commits only then.
- pc  output  XLEN  address of instr.
- pc_plus4  output  XLEN  pc+4, for jal/jalr link.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7_5  output  1  instr[30].
- misaligned_err  output  1  sticky: a taken target was not word-aligned.

Behaviour:
- Reset values (next edge with reset=1): state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), misaligned_err=0.
- State-derived outputs: imem_req=1 only in FETCH; instr_valid=1 only in EXEC. During reset both read as their reset-state values; no fetch is issued until reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, capture imem_rdata into instr and go to EXEC. Otherwise stay; pc and imem_addr stay stable. Ack may arrive in the first FETCH cycle (zero wait).
  - EXEC: instr_valid=1 for one cycle.
    - pc_src = jump | (branch & zero).
    - If pc_src=1 and pc_target[1:0]!=0: set misaligned_err, keep pc unchanged, go to HALT.
    - Otherwise pc <= pc_src ? pc_target : pc+4, then go to FETCH.
  - HALT: imem_req=0, instr_valid=0, all state frozen. Exit only through reset.
- Throughput: minimum 2 cycles per instruction (FETCH with ack, then EXEC). Each extra wait cycle adds one.
- imem_ack outside FETCH is ignored; instr does not change.
- Field outputs (op, funct3, funct7_5) are combinational slices of the registered instr, so they are stable throughout EXEC.
- pc_plus4 is combinational.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no error.
- Reset mid-operation (FETCH with a pending request, or EXEC): the next edge enters the reset state and the outstanding request is abandoned. Memory must tolerate req dropping without an ack.
- Simultaneous imem_ack and reset: reset wins; instr=NOP.
- branch=1 with zero=0: not taken, pc+4. Target alignment is not checked when not taken.

Decomposition:
- Shared package riscv_pkg holds:
  - state enum (FETCH, EXEC, HALT)
  - NOP_INSTR = 32'h0000_0013
  - field bit-position constants (OP_LSB/MSB, FUNCT3_LSB/MSB, FUNCT7_5_BIT)
  - opcode constants shared with the control unit
- One natural combinational sub-module, next_pc_logic: inputs pc, pc_target, branch, jump, zero; outputs next_pc and misaligned.

Test Plan:
- Reset, then deassert with RESET_PC=0 -> imem_req=1, imem_addr=0 in the first cycle; ack with 32'h00500093 -> next cycle instr_valid=1, op=7'h13, funct3=0, pc_plus4=4.
- Ack latency 0 vs 3 cycles -> imem_addr held at 0 for all wait cycles; instr_valid pulses exactly once per instruction; with back-to-back zero-wait acks, instr_valid appears every 2nd cycle.
- EXEC with branch=1, zero=1, pc_target=32'h40 -> next FETCH addr=32'h40. Same with zero=0 -> addr=pc+4.
- jump=1, pc_target=32'h42 -> misaligned_err=1, pc unchanged, imem_req stays 0 indefinitely until reset, which clears it.
- pc=32'hFFFF_FFFC, no branch -> next imem_addr=32'h0000_0000, misaligned_err=0.
- Reset asserted in the second FETCH wait cycle with imem_ack=1 -> instr=NOP, pc=RESET_PC, no instr_valid pulse.
